mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Memory-stage access controller sitting directly upstream of Data_Memory in the MIPS pipeline. Consumes EX/MEM byte address, store value and access size, and drives the word-indexed data memory.
- Adds byte/halfword loads with sign/zero extension and sub-word stores via a 2-cycle read-modify-write, stalling the pipeline during the merge.
- Detects misaligned, out-of-range and conflicting accesses.

Parameters:
- MEM_WORDS, 64, data memory depth in 32-bit words. Valid byte addresses are 0 .. 4*MEM_WORDS-1.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  EX/MEM slot holds a live instruction
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- load_unsigned  in  1  1 = zero-extend sub-word load, 0 = sign-extend
- ALU_result  in  32  byte address
- ST_val  in  32  store data, right-aligned
- dm_rdata  in  32  Data_Memory Mem_read_value
- dm_addr  out  32  word index to Data_Memory = {26'b0, ALU_result[7:2]} for MEM_WORDS=64 (generally ALU_result>>2)
- dm_wdata  out  32  word to Data_Memory ST_val
- dm_w_en  out  1  Data_Memory MEM_W_EN
- dm_r_en  out  1  Data_Memory MEM_R_EN
- load_data  out  32  extended load result to MEM/WB
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_fault  out  1  faulting access this cycle
- fault_addr  out  32  byte address of most recent fault (registered)

Behaviour:
- Access is active when valid & (MEM_R_EN | MEM_W_EN).
- Fault conditions, evaluated in IDLE:
  - half with ALU_result[0]=1
  - word with ALU_result[1:0]≠0
  - size=11
  - ALU_result ≥ 4*MEM_WORDS
  - MEM_R_EN & MEM_W_EN both set
- Fault response: mem_fault=1 (combinational); dm_w_en=0, dm_r_en=0, load_data=0, stall=0; fault_addr<=ALU_result at the next edge.
- Byte lanes are little-endian: byte k is bits [8k+7:8k], k=ALU_result[1:0]. Halfword lane is [15:0] if ALU_result[1]=0, else [31:16].
- Load (1 cycle, no stall): dm_r_en=1. load_data = selected lane, extended to 32 bits per load_unsigned; a word load passes through unchanged. Combinational from dm_rdata, zero latency.
- Word store (1 cycle): dm_w_en=1, dm_wdata=ST_val; write commits at the rising edge.
- Sub-word store uses FSM states IDLE and MERGE:
  - IDLE, valid non-faulting byte/half store: dm_r_en=1, dm_w_en=0, stall=1. merge_q <= dm_rdata with the target lane replaced by ST_val[7:0] / ST_val[15:0]. Go to MERGE.
  - MERGE: dm_w_en=1, dm_wdata=merge_q, dm_addr from the held ALU_result, stall=0. Return to IDLE. Inputs are guaranteed stable because the previous cycle stalled EX/MEM.
  - Faults and all other accesses never leave IDLE.
- Idle cycle (no active access): all enables 0, stall=0, load_data=0, mem_fault=0.
- Reset:
  - state=IDLE, merge_q=0, fault_addr=0.
  - While rst=1, dm_w_en, dm_r_en, stall and mem_fault are forced 0.
  - Reset asserted in MERGE aborts the merge with no write.
- dm_addr is always ALU_result>>2, even when enables are 0, so Data_Memory's unconditional self-write is harmless.
- Latency:
  - load: 0 extra cycles
  - word store: 0 extra cycles
  - sub-word store: 1 stall cycle
  - back-to-back sub-word stores: 2 cycles each

Test Plan:
- Memory word 5 = 0x8899AABB. Byte load at addr 0x16, signed -> load_data=0xFFFFFF99; unsigned -> 0x00000099; no stall.
- Same word, half load at 0x14, signed -> 0xFFFFAABB. Word load at 0x14 -> 0x8899AABB.
- Byte store ST_val=0x000000C3 to 0x15 with word 5 = 0x8899AABB -> stall=1 for exactly one cycle, then dm_w_en=1 with dm_wdata=0x8899C3BB. A subsequent load of word 5 returns that value.
- Half store 0x1234 to 0x13 -> mem_fault=1, no write, fault_addr=0x13 next cycle. Word load at 0x100 (MEM_WORDS=64) -> fault, fault_addr=0x100. MEM_R_EN & MEM_W_EN both set -> fault.
- Assert rst during the MERGE cycle of a byte store -> no dm_w_en pulse, state IDLE, fault_addr=0, memory word unchanged.
- Two consecutive half stores 0xAAAA to 0x20 and 0xBBBB to 0x22, word 8 initially 0 -> 4 cycles total, 2 stall cycles, final word 8 = 0xBBBBAAAA.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller placed in front of a word-indexed data memory.
// Provides byte/halfword loads with sign or zero extension, sub-word stores via a
// two-cycle read-modify-write that stalls the pipeline for one cycle, and flags
// misaligned, out-of-range, reserved-size and read+write conflicting accesses.
module mem_access_ctrl #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    input  logic [31:0] dm_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_w_en,
    output logic        dm_r_en,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        mem_fault,
    output logic [31:0] fault_addr
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StMerge
    } state_e;

    state_e      state_q;
    logic [31:0] merge_q;

    logic        active;
    logic        misaligned;
    logic        fault_cond;
    logic        in_idle;
    logic        do_fault;
    logic        do_load;
    logic        do_wstore;
    logic        do_sstore;
    logic [4:0]  byte_sh;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ext_data;
    logic [31:0] merged;

    // Access classification; faults are only meaningful while idle.
    always_comb begin
        active     = valid & (MEM_R_EN | MEM_W_EN);
        misaligned = ((size == SIZE_HALF) & ALU_result[0]) |
                     ((size == SIZE_WORD) & (ALU_result[1:0] != 2'b00));
        fault_cond = active & (misaligned | (size == SIZE_RSVD) |
                     (ALU_result >= ADDR_LIMIT) | (MEM_R_EN & MEM_W_EN));
        in_idle    = (state_q == StIdle);
        do_fault   = in_idle & fault_cond;
        do_load    = in_idle & active & ~fault_cond & MEM_R_EN;
        do_wstore  = in_idle & active & ~fault_cond & MEM_W_EN & (size == SIZE_WORD);
        do_sstore  = in_idle & active & ~fault_cond & MEM_W_EN & (size != SIZE_WORD);
    end

    // Little-endian lane selection and load extension.
    always_comb begin
        byte_sh   = {ALU_result[1:0], 3'b000};
        byte_lane = dm_rdata[byte_sh +: 8];
        half_lane = ALU_result[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        ext_data  = dm_rdata;
        unique case (size)
            SIZE_BYTE: ext_data = load_unsigned ? {24'b0, byte_lane}
                                                : {{24{byte_lane[7]}}, byte_lane};
            SIZE_HALF: ext_data = load_unsigned ? {16'b0, half_lane}
                                                : {{16{half_lane[15]}}, half_lane};
            default:   ext_data = dm_rdata;
        endcase
    end

    // Read word with the target store lane replaced, captured for the merge write.
    always_comb begin
        merged = dm_rdata;
        if (size == SIZE_BYTE) begin
            merged[byte_sh +: 8] = ST_val[7:0];
        end else if (ALU_result[1]) begin
            merged[31:16] = ST_val[15:0];
        end else begin
            merged[15:0] = ST_val[15:0];
        end
    end

    // Memory-side and pipeline-side outputs; reset masks every enable.
    always_comb begin
        dm_addr   = ALU_result >> 2;
        dm_wdata  = (state_q == StMerge) ? merge_q : ST_val;
        dm_r_en   = ~rst & (do_load | do_sstore);
        dm_w_en   = ~rst & (do_wstore | (state_q == StMerge));
        stall     = ~rst & do_sstore;
        mem_fault = ~rst & do_fault;
        load_data = do_load ? ext_data : 32'b0;
    end

    // IDLE/MERGE sequencing, merge buffer and fault address capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            merge_q    <= 32'b0;
            fault_addr <= 32'b0;
        end else begin
            if (state_q == StIdle) begin
                if (do_sstore) begin
                    merge_q <= merged;
                    state_q <= StMerge;
                end
            end else begin
                state_q <= StIdle;
            end
            if (do_fault) begin
                fault_addr <= ALU_result;
            end
        end
    end

endmodule
